// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and gap derivation for the pipe field
package game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int FIELD_COLS = 16;
  localparam int GAP_ROWS   = 8;

  typedef logic [3:0] col_t;
  typedef logic [2:0] gap_t;

  typedef struct packed {
    gap_t height;
    gap_t size;
  } gap_pair_t;

  // Height is clamped so the whole gap always fits inside the GAP_ROWS rows.
  function automatic gap_pair_t gap_from_lfsr(input logic [7:0] l, input int min_size);
    logic [3:0] size4;
    logic [3:0] limit;
    logic [3:0] h4;
    gap_pair_t  g;
    size4    = 4'(min_size) + {2'b00, l[4:3]};
    limit    = 4'(GAP_ROWS) - size4;
    h4       = {1'b0, l[2:0]};
    if (h4 > limit) h4 = limit;
    g.height = h4[2:0];
    g.size   = size4[2:0];
    return g;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);

  // Maximal-length taps: a non-zero seed can never reach the all-zero lock-up state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/pipe_generator.sv
// rtl/pipe_generator.sv - scrolls two pipes across the field and assigns random gaps
module pipe_generator
  import game_pkg::*;
#(
  parameter int         TICK_DIV   = 25_000_000,
  parameter int         START_COL1 = 15,
  parameter int         START_COL2 = 7,
  parameter int         MIN_SIZE   = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       game_over,
  output logic [3:0] pipe1,
  output logic [3:0] pipe2,
  output logic [2:0] height1,
  output logic [2:0] height2,
  output logic [2:0] size1,
  output logic [2:0] size2,
  output logic       move_strobe,
  output logic       running
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam col_t START1 = 4'(START_COL1);
  localparam col_t START2 = 4'(START_COL2);

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [7:0]        lfsr_q;
  gap_pair_t         new_gap;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign new_gap = gap_from_lfsr(lfsr_q, MIN_SIZE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      pipe1       <= START1;
      pipe2       <= START2;
      height1     <= 3'd2;
      height2     <= 3'd2;
      size1       <= 3'd4;
      size2       <= 3'd4;
      move_strobe <= 1'b0;
      running     <= 1'b0;
    end else begin
      move_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            running  <= 1'b1;
            tick_cnt <= '0;
          end
        end
        RUN: begin
          // game_over takes priority over a coinciding tick
          if (game_over) begin
            state   <= OVER;
            running <= 1'b0;
          end else if (tick_cnt == CNT_LAST) begin
            tick_cnt    <= '0;
            move_strobe <= 1'b1;
            pipe1       <= pipe1 - 4'd1;
            pipe2       <= pipe2 - 4'd1;
            if (pipe1 == 4'd0) begin
              height1 <= new_gap.height;
              size1   <= new_gap.size;
            end
            if (pipe2 == 4'd0) begin
              height2 <= new_gap.height;
              size2   <= new_gap.size;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        OVER: begin
          if (start) begin
            state    <= RUN;
            running  <= 1'b1;
            tick_cnt <= '0;
            pipe1    <= START1;
            pipe2    <= START2;
            height1  <= new_gap.height;
            size1    <= new_gap.size;
            height2  <= new_gap.height;
            size2    <= new_gap.size;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_generator.sv
// tb/tb_pipe_generator.sv - directed self-checking bench for pipe_generator
module tb_pipe_generator;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] pipe1, pipe2;
  logic [2:0] height1, height2, size1, size2;
  logic       move_strobe, running;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  always #5 clock = ~clock;

  pipe_generator #(
    .TICK_DIV   (4),
    .START_COL1 (15),
    .START_COL2 (7),
    .MIN_SIZE   (2),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .game_over   (game_over),
    .pipe1       (pipe1),
    .pipe2       (pipe2),
    .height1     (height1),
    .height2     (height2),
    .size1       (size1),
    .size2       (size2),
    .move_strobe (move_strobe),
    .running     (running)
  );

  // Reference LFSR; m_prev holds the value present at the most recent edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  function automatic logic [2:0] exp_size(input logic [7:0] l);
    return 3'd2 + {1'b0, l[4:3]};
  endfunction

  function automatic logic [2:0] exp_height(input logic [7:0] l);
    int s, lim;
    s   = 2 + int'(l[4:3]);
    lim = 8 - s;
    return (int'(l[2:0]) > lim) ? 3'(lim) : l[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (move_strobe !== 1'b1 && n < 20);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pipe1"}, pipe1, 15);
    check({tag, "_pipe2"}, pipe2, 7);
    check({tag, "_h1"}, height1, 2);
    check({tag, "_s1"}, size1, 4);
    check({tag, "_h2"}, height2, 2);
    check({tag, "_s2"}, size2, 4);
    check({tag, "_running"}, running, 0);
    check({tag, "_strobe"}, move_strobe, 0);
  endtask

  initial begin
    int n;
    logic [7:0] l;
    logic [2:0] fh1, fs1, fh2, fs2;

    repeat (3) @(negedge clock);
    check_reset_vals("reset_hold");
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("reset_rel");

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle_pipe1", pipe1, 15);
      check("idle_pipe2", pipe2, 7);
      check("idle_strobe", move_strobe, 0);
    end

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_running", running, 1);
    check("start_strobe", move_strobe, 0);
    wait_strobe(n);
    check("first_strobe_lat", n, 4);
    check("move1_pipe1", pipe1, 14);
    check("move1_pipe2", pipe2, 6);
    check("move1_h1", height1, 2);
    check("move1_s2", size2, 4);
    wait_strobe(n);
    check("second_strobe_lat", n, 4);
    check("move2_pipe1", pipe1, 13);
    check("move2_pipe2", pipe2, 5);

    for (int i = 0; i < 5; i++) begin
      wait_strobe(n);
      check("pre_wrap_lat", n, 4);
    end
    check("pre_wrap_pipe2", pipe2, 0);
    check("pre_wrap_pipe1", pipe1, 8);

    wait_strobe(n);
    l = m_prev;
    check("wrap_lat", n, 4);
    check("wrap_pipe2", pipe2, 15);
    check("wrap_pipe1", pipe1, 7);
    check("wrap_h2", height2, exp_height(l));
    check("wrap_s2", size2, exp_size(l));
    check("wrap_s2_range", (size2 >= 3'd2 && size2 <= 3'd5), 1);
    check("wrap_fit", ({1'b0, height2} + {1'b0, size2} <= 4'd8), 1);
    check("wrap_h1_kept", height1, 2);
    check("wrap_s1_kept", size1, 4);

    repeat (3) @(negedge clock);
    game_over = 1'b1;
    @(negedge clock);
    check("go_tick_strobe", move_strobe, 0);
    check("go_tick_pipe1", pipe1, 7);
    check("go_tick_pipe2", pipe2, 15);
    check("go_running", running, 0);
    game_over = 1'b0;
    fh2 = height2;
    fs2 = size2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("over_strobe", move_strobe, 0);
      check("over_pipe1", pipe1, 7);
      check("over_pipe2", pipe2, 15);
      check("over_h2", height2, fh2);
      check("over_s2", size2, fs2);
      check("over_running", running, 0);
    end

    start = 1'b1;
    game_over = 1'b1;
    @(negedge clock);
    start = 1'b0;
    game_over = 1'b0;
    l = m_prev;
    fh1 = exp_height(l);
    fs1 = exp_size(l);
    check("restart_pipe1", pipe1, 15);
    check("restart_pipe2", pipe2, 7);
    check("restart_running", running, 1);
    check("restart_h1", height1, fh1);
    check("restart_s1", size1, fs1);
    check("restart_h2", height2, fh1);
    check("restart_s2", size2, fs1);
    wait_strobe(n);
    check("restart_lat", n, 4);
    check("restart_pipe1_mv", pipe1, 14);
    check("restart_pipe2_mv", pipe2, 6);

    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("post_rst_pipe1", pipe1, 15);
      check("post_rst_pipe2", pipe2, 7);
      check("post_rst_running", running, 0);
      check("post_rst_strobe", move_strobe, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
